// File: rtl/proc_pkg.sv
// Shared opcode map, FSM state encoding and default parameters for param_processor.
// The optional multiplier is enabled with the PROC_MUL_EN macro.
package proc_pkg;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_IADDR_W = 9;
  localparam int DEF_DADDR_W = 16;
  localparam int DEF_NREG    = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_MOV  = 4'h2,
    OP_MVA  = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_SHR  = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_JNZ  = 4'h9,
    OP_MUL  = 4'hA,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_HALT   = 3'd4
  } state_t;

endpackage

// File: rtl/proc_alu.sv
// Accumulator ALU: ADD/SUB/logical SHR, plus MUL when PROC_MUL_EN is defined.
// Without PROC_MUL_EN no multiplier exists and opcode A produces no result here.
module proc_alu
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [3:0]        i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [3:0]        i_n,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero
);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_ADD:  o_result = i_a + i_b;
      OP_SUB:  o_result = i_a - i_b;
      OP_SHR:  o_result = i_a >> i_n;
`ifdef PROC_MUL_EN
      OP_MUL:  o_result = DATA_W'(i_a * i_b);
`endif
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/param_processor.sv
// Tiny accumulator CPU: 3-cycle FETCH/DECODE/EXEC, byte-wide handshaked data port.
// Opcode A multiplies only when PROC_MUL_EN is defined; otherwise it is a NOP.
//
// state  | meaning
// FETCH  | ins_addr = PC, instruction byte requested
// DECODE | IR <= ins_data, PC <= PC + 1
// EXEC   | execute; LD/ST go to MEM, HALT goes to HALT
// MEM    | mem_req held until mem_ack
// HALT   | terminal until reset, finished = 1
module param_processor
  import proc_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int IADDR_W = DEF_IADDR_W,
  parameter int DADDR_W = DEF_DADDR_W,
  parameter int NREG    = DEF_NREG
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IADDR_W-1:0] ins_addr,
  input  logic [7:0]         ins_data,
  output logic               mem_req,
  output logic               mem_we,
  output logic [DADDR_W-1:0] mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ack,
  output logic               finished
);

  localparam int RSEL_W = $clog2(NREG);

  state_t             r_state;
  logic [IADDR_W-1:0] r_pc;
  logic [7:0]         r_ir;
  logic [DATA_W-1:0]  r_ac;
  logic               r_z;
  logic [DATA_W-1:0]  r_regs [NREG];
  logic               r_mem_req;
  logic               r_mem_we;
  logic [DADDR_W-1:0] r_mem_addr;
  logic [7:0]         r_mem_wdata;
  logic               r_finished;

  logic [3:0]         w_op;
  logic [3:0]         w_n;
  logic [RSEL_W-1:0]  w_rsel;
  logic [DATA_W-1:0]  w_rn;
  logic [DATA_W-1:0]  w_imm;
  logic [DATA_W-1:0]  w_ld;
  logic [DATA_W-1:0]  w_alu_res;
  logic               w_alu_zero;

  assign w_op   = r_ir[7:4];
  assign w_n    = r_ir[3:0];
  assign w_rsel = RSEL_W'(int'(w_n) % NREG);
  assign w_rn   = r_regs[w_rsel];
  assign w_imm  = DATA_W'(w_n);
  assign w_ld   = DATA_W'(mem_rdata);

  proc_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op     (w_op),
    .i_a      (r_ac),
    .i_b      (w_rn),
    .i_n      (w_n),
    .o_result (w_alu_res),
    .o_zero   (w_alu_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_FETCH;
      r_pc        <= '0;
      r_ir        <= '0;
      r_ac        <= '0;
      r_z         <= 1'b0;
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_finished  <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          r_ir    <= ins_data;
          r_pc    <= r_pc + IADDR_W'(1);
          r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          r_state <= ST_FETCH;
          case (w_op)
            OP_LDI: begin
              r_ac <= w_imm;
              r_z  <= (w_n == 4'd0);
            end
            OP_MOV: r_regs[w_rsel] <= r_ac;
            OP_MVA: begin
              r_ac <= w_rn;
              r_z  <= (w_rn == '0);
            end
`ifdef PROC_MUL_EN
            OP_ADD, OP_SUB, OP_SHR, OP_MUL: begin
`else
            OP_ADD, OP_SUB, OP_SHR: begin
`endif
              r_ac <= w_alu_res;
              r_z  <= w_alu_zero;
            end
            OP_LD, OP_ST: begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= (w_op == OP_ST);
              r_mem_addr  <= w_rn[DADDR_W-1:0];
              r_mem_wdata <= r_ac[7:0];
              r_state     <= ST_MEM;
            end
            // PC already points past the JNZ, so n=1 lands on the JNZ itself
            OP_JNZ: if (!r_z) r_pc <= r_pc - IADDR_W'(w_n);
            OP_HALT: begin
              r_finished <= 1'b1;
              r_state    <= ST_HALT;
            end
            default: ;
          endcase
        end
        ST_MEM: begin
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_ac <= w_ld;
              r_z  <= (mem_rdata == 8'd0);
            end
            r_state <= ST_FETCH;
          end
        end
        ST_HALT: r_state <= ST_HALT;
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign ins_addr  = r_pc;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign finished  = r_finished;

endmodule

// File: tb/tb_param_processor.sv
// Directed bench for param_processor: table of small programs plus hand sequences
// for the data-port handshake and reset during a memory wait.
module tb_param_processor;
  import proc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [8:0]  ins_addr;
  logic [7:0]  ins_data;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        finished;

  logic [8:0]  ins_addr8;
  logic [7:0]  ins_data8;
  logic        mem_req8, mem_we8, finished8;
  logic [7:0]  mem_addr8, mem_wdata8;
  logic [7:0]  mem_rdata8;
  logic        mem_ack8;

  param_processor dut (
    .clk(clk), .rst_n(rst_n), .ins_addr(ins_addr), .ins_data(ins_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .finished(finished)
  );

  param_processor #(.DATA_W(8), .DADDR_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .ins_addr(ins_addr8), .ins_data(ins_data8),
    .mem_req(mem_req8), .mem_we(mem_we8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_rdata(mem_rdata8), .mem_ack(mem_ack8), .finished(finished8)
  );

`ifdef PROC_MUL_EN
  localparam logic [15:0] MUL_EXP = 16'd42;
`else
  localparam logic [15:0] MUL_EXP = 16'd7;
`endif

  logic [7:0] prog [512];
  logic [7:0] dmem [256];
  int         mem_wait;
  int         wr_cycles;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  bit          wr_unstable;
  int          n_cmp, n_err;

  typedef struct {
    logic [127:0] code;
    int           cyc;
    logic [15:0]  ac;
    logic         z;
    logic [8:0]   pc;
    logic [15:0]  r1;
    bit           chk8;
    logic [7:0]   ac8;
  } vec_t;

  vec_t vecs [13];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // instruction ROMs answer the address presented in FETCH during DECODE
  initial begin
    ins_data = 8'h00;
    ins_data8 = 8'h00;
    forever begin
      @(negedge clk);
      ins_data  = prog[ins_addr];
      ins_data8 = prog[ins_addr8];
    end
  end

  // data memory: acks after mem_wait idle cycles of mem_req
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    mem_ack8 = 1'b0;
    mem_rdata8 = 8'h00;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (mem_req) begin
        if (mem_we) begin
          wr_cycles++;
          if (wr_cycles == 1) begin
            wr_addr = mem_addr;
            wr_data = mem_wdata;
          end else if (mem_addr !== wr_addr || mem_wdata !== wr_data) begin
            wr_unstable = 1'b1;
          end
        end
        if (cnt == mem_wait) begin
          mem_ack = 1'b1;
          if (mem_we) dmem[mem_addr[7:0]] = mem_wdata;
          else mem_rdata = dmem[mem_addr[7:0]];
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic load_prog(input logic [127:0] code);
    for (int i = 0; i < 512; i++) prog[i] = 8'hF0;
    for (int i = 0; i < 16; i++) prog[i] = code[i*8 +: 8];
  endtask

  task automatic reset_and_release();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_fin(input int bound, output int cyc, output bit done);
    cyc = 0;
    done = 1'b0;
    while (!done && cyc < bound) begin
      @(negedge clk);
      cyc++;
      if (finished) done = 1'b1;
    end
  endtask

  initial begin
    int  cyc;
    bit  done;
    logic [8:0] pc_snap;

    n_cmp = 0; n_err = 0;
    mem_wait = 1; wr_cycles = 0; wr_addr = '0; wr_data = '0; wr_unstable = 1'b0;
    for (int i = 0; i < 256; i++) dmem[i] = 8'h00;
    dmem[0] = 8'hA5;
    load_prog(128'hF0);

    //            code                                        cyc  ac         z     pc     r1        chk8  ac8
    vecs[0]  = '{128'hF0_41_13_21_15,                          15, 16'd8,     1'b0, 9'd5, 16'd5,   1'b0, 8'h00};
    vecs[1]  = '{128'hF0_94_21_52_31_22_11_21_13,              51, 16'd0,     1'b1, 9'd9, 16'd0,   1'b0, 8'h00};
    vecs[2]  = '{128'hF0_62_1F,                                 9, 16'd3,     1'b0, 9'd3, 16'd0,   1'b0, 8'h00};
    vecs[3]  = '{128'hF0_A0_17_20_16,                          15, MUL_EXP,   1'b0, 9'd5, 16'd0,   1'b0, 8'h00};
    vecs[4]  = '{128'hF0_61_11,                                 9, 16'd0,     1'b1, 9'd3, 16'd0,   1'b0, 8'h00};
    vecs[5]  = '{128'hF0_31_10_25_19,                          15, 16'd9,     1'b0, 9'd5, 16'd9,   1'b0, 8'h00};
    vecs[6]  = '{128'hF0_50_10_20_11,                          15, 16'hFFFF,  1'b0, 9'd5, 16'd0,   1'b1, 8'hFF};
    vecs[7]  = '{128'hF0_21_10,                                 9, 16'd0,     1'b1, 9'd3, 16'd0,   1'b0, 8'h00};
    vecs[8]  = '{128'hF0_00_B0_12,                             12, 16'd2,     1'b0, 9'd4, 16'd0,   1'b0, 8'h00};
    vecs[9]  = '{128'hF0_91_10,                                 9, 16'd0,     1'b1, 9'd3, 16'd0,   1'b0, 8'h00};
    vecs[10] = '{128'hF0_90_11,                                 9, 16'd1,     1'b0, 9'd3, 16'd0,   1'b0, 8'h00};
    vecs[11] = '{128'hF0_72_19_22_13,                          17, 16'd0,     1'b1, 9'd5, 16'd0,   1'b0, 8'h00};
    vecs[12] = '{128'hF0_70,                                    8, 16'h00A5,  1'b0, 9'd2, 16'd0,   1'b0, 8'h00};

    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.finished", finished, 0);
    chk("rst.mem_req", mem_req, 0);
    chk("rst.mem_we", mem_we, 0);
    chk("rst.mem_addr", mem_addr, 0);
    chk("rst.mem_wdata", mem_wdata, 0);
    chk("rst.ins_addr", ins_addr, 0);
    chk("rst.ac", dut.r_ac, 0);
    chk("rst.z", dut.r_z, 0);
    chk("rst.ir", dut.r_ir, 0);

    foreach (vecs[i]) begin
      load_prog(vecs[i].code);
      mem_wait = 1;
      reset_and_release();
      wait_fin(400, cyc, done);
      chk($sformatf("v%0d.done", i), done, 1);
      chk($sformatf("v%0d.cycles", i), cyc, vecs[i].cyc);
      repeat (3) @(negedge clk);
      chk($sformatf("v%0d.finished", i), finished, 1);
      chk($sformatf("v%0d.ac", i), dut.r_ac, vecs[i].ac);
      chk($sformatf("v%0d.z", i), dut.r_z, vecs[i].z);
      chk($sformatf("v%0d.pc", i), dut.r_pc, vecs[i].pc);
      chk($sformatf("v%0d.r1", i), dut.r_regs[1], vecs[i].r1);
      chk($sformatf("v%0d.mem_req", i), mem_req, 0);
      if (vecs[i].chk8) begin
        chk($sformatf("v%0d.ac8", i), dut8.r_ac, vecs[i].ac8);
        chk($sformatf("v%0d.z8", i), dut8.r_z, 0);
      end
    end

    // store with a 4-cycle wait: R0 built up to 0x20, AC restored to 0xA5
    load_prog(128'hF0_80_31_20_40_20_40_20_18_21_70);
    dmem[8'h20] = 8'h00;
    mem_wait = 4;
    wr_cycles = 0;
    wr_unstable = 1'b0;
    reset_and_release();
    wait_fin(400, cyc, done);
    chk("st.done", done, 1);
    chk("st.req_cycles", wr_cycles, 5);
    chk("st.addr", wr_addr, 16'h0020);
    chk("st.wdata", wr_data, 8'hA5);
    chk("st.stable", wr_unstable, 0);
    chk("st.dmem", dmem[8'h20], 8'hA5);
    chk("st.ac", dut.r_ac, 16'h00A5);

    // HALT holds PC and ignores further cycles
    pc_snap = dut.r_pc;
    repeat (5) @(negedge clk);
    chk("halt.pc_frozen", dut.r_pc, pc_snap);
    chk("halt.pc", pc_snap, 9'd11);

    // reset in the middle of an unacknowledged load
    load_prog(128'hF0_70);
    mem_wait = 100000;
    reset_and_release();
    cyc = 0;
    while (!mem_req && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid.req_seen", mem_req, 1);
    repeat (6) @(negedge clk);
    chk("mid.req_held", mem_req, 1);
    chk("mid.we", mem_we, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid.req_drop", mem_req, 0);
    chk("mid.pc", dut.r_pc, 0);
    chk("mid.state", dut.r_state, ST_FETCH);
    chk("mid.finished", finished, 0);
    chk("mid.ins_addr", ins_addr, 0);
    rst_n = 1'b1;
    mem_wait = 1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/param_processor.md
PARAM_PROCESSOR -- requirements
Module: param_processor

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning accumulator, register and ALU width (min 8).
REQ-002 The block SHALL have parameter IADDR_W, default 9, meaning program-counter and instruction-address width.
REQ-003 The block SHALL have parameter DADDR_W, default 16, meaning data-address width (≤ DATA_W).
REQ-004 The block SHALL have parameter NREG, default 4, meaning general registers R0..NREG-1 (2..16).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 The block SHALL have port ins_addr, output, IADDR_W bits: instruction address.
REQ-008 The block SHALL have port ins_data, input, 8 bits: instruction byte, valid one cycle after ins_addr.
REQ-009 The block SHALL have port mem_req, output, 1 bit: data access request.
REQ-010 The block SHALL have port mem_we, output, 1 bit: 1 = write, 0 = read; valid while mem_req.
REQ-011 The block SHALL have port mem_addr, output, DADDR_W bits: data address.
REQ-012 The block SHALL have port mem_wdata, output, 8 bits: write byte.
REQ-013 The block SHALL have port mem_rdata, input, 8 bits: read byte, valid with mem_ack.
REQ-014 The block SHALL have port mem_ack, input, 1 bit: access complete.
REQ-015 The block SHALL have port finished, output, 1 bit: high while halted.

Function
REQ-016 Instruction format SHALL be [7:4] opcode, [3:0] operand n; register operand Rn uses n mod NREG.
REQ-017 Opcodes SHALL be: 0 NOP; 1 LDI AC=n (zero-ext); 2 MOV Rn=AC; 3 MVA AC=Rn; 4 ADD AC+=Rn; 5 SUB AC-=Rn; 6 SHR AC>>=n (logical); 7 LD AC=mem[Rn] (zero-ext); 8 ST mem[Rn]=AC[7:0]; 9 JNZ: if Z==0, PC=PC-n; A MUL (macro-gated); B-E NOP; F HALT.
REQ-018 Arithmetic SHALL wrap modulo 2^DATA_W; mem_addr SHALL be Rn[DADDR_W-1:0].
REQ-019 Flag Z SHALL update on ADD/SUB/SHR/MUL/LDI/MVA/LD to (AC_result==0); otherwise hold.
REQ-020 FSM states SHALL be FETCH, DECODE, EXEC, MEM, HALT.
REQ-021 FETCH: drive ins_addr=PC; next DECODE.
REQ-022 DECODE: IR<=ins_data, PC<=PC+1 (wraps at 2^IADDR_W); next EXEC.
REQ-023 EXEC: non-memory ops complete and return to FETCH (3 cycles/instruction); LD/ST go to MEM; HALT goes to HALT.
REQ-024 JNZ SHALL use the already-incremented PC; n=1 re-executes JNZ itself; subtraction wraps.
REQ-025 MEM: mem_req=1 with stable mem_we/mem_addr/mem_wdata until the cycle mem_ack=1; that cycle LD captures mem_rdata, then FETCH; mem_req SHALL drop the following cycle.
REQ-026 mem_ack outside MEM SHALL be ignored; wait length is unbounded.
REQ-027 HALT SHALL be terminal until reset; finished=1, mem_req=0, PC frozen.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force state FETCH, PC=0, AC=0, Rn=0, IR=0, Z=0, mem_req=0, mem_we=0, finished=0, from any state including mid-MEM.
REQ-029 mem_addr, mem_wdata and ins_addr SHALL read 0 during and after reset until first use.

Configuration
REQ-030 With PROC_MUL_EN defined, opcode A SHALL compute AC=(AC*Rn) truncated to DATA_W in EXEC, updating Z.
REQ-031 Without PROC_MUL_EN, opcode A SHALL execute as NOP and no multiplier SHALL be synthesised.

Structure
REQ-032 Opcode constants, FSM state encoding and default parameter values SHALL live in shared package proc_pkg.
REQ-033 ALU (ADD/SUB/SHR/MUL, zero detect) SHALL be sub-module proc_alu; register file, FSM and PC stay in param_processor.

Verification
REQ-034 Reset then LDI 5, MOV R1, LDI 3, ADD R1, HALT -> AC=8, Z=0, finished=1 at cycle 15, PC=5.
REQ-035 R0=0x20, ST with AC=0xA5, mem_ack after 4 wait cycles -> mem_req high exactly 5 cycles, mem_addr=0x20, mem_wdata=0xA5, mem_we=1.
REQ-036 Loop LDI 3, MOV R1, LDI 1, MOV R2, MVA R1, SUB R2, MOV R1, JNZ 4, HALT -> body runs 3 times, R1=0, finished=1.
REQ-037 LD R0 with mem_rdata=0x00 -> AC=0, Z=1; rst_n=0 asserted during MEM wait -> mem_req=0 next cycle, PC=0.
REQ-038 LDI 15, SHR 2 -> AC=3; opcode A with AC=7, R0=6 -> AC=42 with PROC_MUL_EN, AC=7 without.
REQ-039 DATA_W=8: LDI 1, MOV R0, LDI 0, SUB R0 -> AC=0xFF, Z=0.
